// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one left barrel shifter between two requesters
// Optional feature macro: SHIFT_ARB_OVF_EN (adds rsp_ovf, set when operand bits are shifted out)

module barrel_shifter_left #(
    parameter int N     = 16,
    parameter int LOG_N = $clog2(N)
) (
    input  logic [N-1:0]   i_a,
    input  logic [LOG_N:0] i_shift,
    output logic [N-1:0]   o_y
);

    logic [N-1:0] w_stage [0:LOG_N];

    assign w_stage[0] = i_a;

    // One conditional power-of-two shift stage per bit of the shift amount below the top bit
    for (genvar g = 0; g < LOG_N; g++) begin : g_stage
        localparam int SH = 1 << g;
        assign w_stage[g+1] = i_shift[g] ? (w_stage[g] << SH) : w_stage[g];
    end

    // Top shift bit means an amount of N or more, which clears every bit
    assign o_y = i_shift[LOG_N] ? '0 : w_stage[LOG_N];

endmodule

module shift_arbiter #(
    parameter  int N     = 16,
    localparam int LOG_N = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [LOG_N:0] req0_shift,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [LOG_N:0] req1_shift,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
`ifdef SHIFT_ARB_OVF_EN
    output logic [N-1:0]   rsp_o,
    output logic           rsp_ovf
`else
    output logic [N-1:0]   rsp_o
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;
    logic           r_rr;
    logic [N-1:0]   r_rsp;

    logic           w_drain;
    logic           w_can_issue;
    logic           w_any_valid;
    logic           w_pick1;
    logic           w_grant;
    logic [N-1:0]   w_sel_a;
    logic [LOG_N:0] w_sel_shift;
    logic [N-1:0]   w_shifted;

    // The held result leaves when its owner accepts it; the other requester's ready is ignored
    assign w_drain     = (r_state == ST_FULL) && (r_owner ? rsp1_ready : rsp0_ready);
    assign w_can_issue = (r_state == ST_EMPTY) || w_drain;

    // Requester 1 wins when it is alone or when both are valid and it holds priority
    assign w_any_valid = req0_valid || req1_valid;
    assign w_pick1     = req1_valid && (!req0_valid || r_rr);
    assign w_grant     = rst && w_any_valid && w_can_issue;

    assign req0_ready  = w_grant && !w_pick1;
    assign req1_ready  = w_grant && w_pick1;

    assign w_sel_a     = w_pick1 ? req1_a     : req0_a;
    assign w_sel_shift = w_pick1 ? req1_shift : req0_shift;

    barrel_shifter_left #(
        .N     (N),
        .LOG_N (LOG_N)
    ) u_shifter (
        .i_a     (w_sel_a),
        .i_shift (w_sel_shift),
        .o_y     (w_shifted)
    );

    // Result register occupancy: a grant refills it, a drain without grant empties it
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = ST_FULL;
        end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State, owner, priority pointer and result data update
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
            r_rsp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rsp   <= w_shifted;
                r_owner <= w_pick1;
                r_rr    <= ~w_pick1;
            end
        end
    end

    assign rsp0_valid = (r_state == ST_FULL) && !r_owner;
    assign rsp1_valid = (r_state == ST_FULL) &&  r_owner;
    assign rsp_o      = r_rsp;

`ifdef SHIFT_ARB_OVF_EN
    logic [2*N-1:0] w_wide;
    logic           w_ovf;
    logic           r_ovf;

    // Below N the double-width shift loses nothing, so its upper half holds the shifted-out bits
    assign w_wide = {{N{1'b0}}, w_sel_a} << w_sel_shift;
    assign w_ovf  = w_sel_shift[LOG_N] ? (|w_sel_a) : (|w_wide[2*N-1:N]);

    // Overflow flag travels with the result it describes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_grant) begin
            r_ovf <= w_ovf;
        end
    end

    assign rsp_ovf = r_ovf;
`else
`endif

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Round-robin arbiter that shares one barrel_shifter_left instance between two requesters, e.g. the x-path and y-path of a sequential CORDIC iteration unit.
- Each requester has its own valid/ready request channel and valid/ready response channel.
- The shifted result is registered, so throughput is one operation per cycle and latency is 1 cycle.

Parameters:
- N, 16, data width of operand and result.
- LOG_N, $clog2(N), derived (localparam); shift port width is LOG_N+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  N  requester 0 operand.
- req0_shift  in  LOG_N+1  requester 0 left-shift amount.
- req1_valid, req1_ready, req1_a, req1_shift  same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 consumes result.
- rsp_o  out  N  registered result, shared by both response channels; qualified by rsp0_valid/rsp1_valid.

Behaviour:
- Reset (rst=0 at an edge):
  - Result register emptied; rsp0_valid=rsp1_valid=0; rsp_o=0.
  - Round-robin pointer rr=0, so requester 0 has priority first.
  - Reset overrides any in-flight or held result, which is discarded.
- Result register: single entry {out_valid, owner, rsp_o}.
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - rspX_valid = out_valid && owner==X.
- drain = out_valid && rsp_ready of the owning requester.
- can_issue = !out_valid || drain. This is a pass-through pipeline: accept and drain may happen in the same cycle.
- Arbitration (combinational):
  - Only one valid: that requester wins.
  - Both valid: requester rr wins.
  - grant only when can_issue.
  - reqX_ready = grantX; at most one ready high per cycle.
- On grant to X (at the edge):
  - rsp_o <= shift(reqX_a, reqX_shift); owner <= X; out_valid <= 1.
  - rr <= ~X, so the loser gets next priority.
- No grant and drain: out_valid <= 0; rsp_o holds its last value.
- No grant and no drain in FULL: everything holds.
  - The losing requester keeps valid high with stable a/shift until its ready.
  - A lower-priority requester may be stalled at most one grant.
- Shift arithmetic: logical left shift, zero fill, upper bits discarded.
  - shift >= N (values N..2N-1) gives result 0.
  - shift = 0 passes the operand through.
- Latency: accept in cycle t gives rspX_valid high in cycle t+1. Back-to-back accepts are allowed while the owner drains every cycle.
- rsp_ready of the non-owning requester is ignored.
- reqX_valid deasserted without ready: legal, request withdrawn, no state change.

Optional Feature:
- Macro SHIFT_ARB_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), registered alongside rsp_o.
  - rsp_ovf=1 iff any 1 bit of the operand was shifted out: (a >> (N-shift)) != 0 for 0<shift<N; a != 0 for shift>=N; 0 for shift=0.
  - Reset value 0.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset: rst=0 for 2 cycles with both req valid -> req ready=0, rsp valid=0, rsp_o=0; release, first grant goes to requester 0.
- Single requester: req0 a=16'hAAAA, shift=1 -> rsp0_valid next cycle, rsp_o=16'h5554; shift=5'h10 -> 16'h0000; shift=5'h1F -> 16'h0000; a=16'h0001, shift=5'h0F -> 16'h8000.
- Contention: both valid every cycle, rsp ready tied 1 -> grants alternate 0,1,0,1; a 1-cycle result each; throughput 1/cycle.
- Backpressure: rsp1_ready=0 for 3 cycles while holding a result -> both req ready=0, rsp_o stable; on rsp1_ready=1, same-cycle drain plus new grant to requester 0.
- Mid-operation reset: rst=0 while out_valid=1 -> next cycle rsp valid=0, rr=0; the held result is never delivered.
- SHIFT_ARB_OVF_EN:
  - a=16'hAAAA shift 1 -> rsp_ovf=1.
  - a=16'h0001 shift 15 -> rsp_ovf=0.
  - a=16'h0001 shift 16 -> rsp_ovf=1.
  - Without macro: compiles with no rsp_ovf port.
